ula_acumulador: RTL and testbench

ULA_ACUMULADOR -- requirements
Module: ula_acumulador

---
 rtl/ula_acumulador_pkg.sv | 22 ++
 rtl/ula_acumulador_ula.sv | 42 ++++
 rtl/ula_acumulador.sv | 111 +++++++++++
 tb/tb_ula_acumulador.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_acumulador_pkg.sv
// Shared definitions for the accumulator ALU block: default widths,
// operation codes and FSM state encoding.
package ula_acumulador_pkg;

    localparam int NBITS_PADRAO   = 8;
    localparam int NSELECT_PADRAO = 2;

    // Operation codes applied as (acc op operand)
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] estado_t;
    localparam estado_t OCIOSO  = 2'd0;
    localparam estado_t EXECUTA = 2'd1;
    localparam estado_t ENTREGA = 2'd2;

endpackage

// File: rtl/ula_acumulador_ula.sv
// Combinational ALU (ULA): AND, OR, two's complement ADD and SUB with
// signed overflow detection. Logic operations never report overflow.
module ula_acumulador_ula
    import ula_acumulador_pkg::*;
#(
    parameter int NBITS   = NBITS_PADRAO,
    parameter int NSELECT = NSELECT_PADRAO
) (
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    input  logic [NSELECT-1:0] f,
    output logic [NBITS-1:0]   y,
    output logic               ovf
);

    op_e op;

    assign op = op_e'(f[1:0]);

    // Result and overflow; overflow looks only at the sign bits of a, b and y
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_ADD: begin
                y   = a + b;
                ovf = (a[NBITS-1] == b[NBITS-1]) && (y[NBITS-1] != a[NBITS-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[NBITS-1] != b[NBITS-1]) && (y[NBITS-1] != a[NBITS-1]);
            end
            default: begin
                y   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_acumulador.sv
// Accumulator around the ULA with a valid/ready command port and a
// valid/ready result port. Each command takes three states:
// OCIOSO (accept), EXECUTA (update accumulator), ENTREGA (hold result).
module ula_acumulador
    import ula_acumulador_pkg::*;
#(
    parameter int NBITS   = NBITS_PADRAO,
    parameter int NSELECT = NSELECT_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [NSELECT-1:0]      cmd_op,
    input  logic                    cmd_carrega,
    input  logic signed [NBITS-1:0] cmd_dado,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [NBITS-1:0] res_dado,
    output logic                    res_flag,
    output logic                    ovf_sticky,
    input  logic                    clr_sticky,
    output logic [7:0]              cnt_ops
);

    estado_t            estado;
    estado_t            prox_estado;
    logic [NBITS-1:0]   acc;
    logic               flag;
    logic [NSELECT-1:0] op_reg;
    logic               carrega_reg;
    logic [NBITS-1:0]   b_reg;
    logic [NBITS-1:0]   ula_y;
    logic               ula_ovf;

    ula_acumulador_ula #(
        .NBITS   (NBITS),
        .NSELECT (NSELECT)
    ) u_ula (
        .a   (acc),
        .b   (b_reg),
        .f   (op_reg),
        .y   (ula_y),
        .ovf (ula_ovf)
    );

    assign res_dado = acc;
    assign res_flag = flag;

    // Next state and handshake outputs decoded from the current state only
    always_comb begin
        prox_estado = estado;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        case (estado)
            OCIOSO: begin
                cmd_ready = 1'b1;
                if (cmd_valid) prox_estado = EXECUTA;
            end
            EXECUTA: prox_estado = ENTREGA;
            ENTREGA: begin
                res_valid = 1'b1;
                if (res_ready) prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // State, captured command, accumulator, flags and delivered-result counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= OCIOSO;
            acc         <= '0;
            flag        <= 1'b0;
            op_reg      <= '0;
            carrega_reg <= 1'b0;
            b_reg       <= '0;
            ovf_sticky  <= 1'b0;
            cnt_ops     <= 8'd0;
        end else begin
            estado <= prox_estado;

            if (estado == OCIOSO && cmd_valid) begin
                op_reg      <= cmd_op;
                carrega_reg <= cmd_carrega;
                b_reg       <= cmd_dado;
            end

            if (estado == EXECUTA) begin
                if (carrega_reg) begin
                    acc  <= b_reg;
                    flag <= 1'b0;
                end else begin
                    acc  <= ula_y;
                    flag <= ula_ovf;
                end
            end

            if (estado == EXECUTA && !carrega_reg && ula_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end

            if (estado == ENTREGA && res_ready) begin
                cnt_ops <= cnt_ops + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ula_acumulador.sv
// Directed self-checking bench for ula_acumulador (NBITS=8, NSELECT=2).
module tb_ula_acumulador;
    import ula_acumulador_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              cmd_carrega;
    logic signed [7:0] cmd_dado;
    logic              res_valid;
    logic              res_ready;
    logic signed [7:0] res_dado;
    logic              res_flag;
    logic              ovf_sticky;
    logic              clr_sticky;
    logic [7:0]        cnt_ops;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] got;
    logic       got_f;
    logic       ok;

    ula_acumulador #(
        .NBITS   (8),
        .NSELECT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_carrega (cmd_carrega),
        .cmd_dado    (cmd_dado),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_dado    (res_dado),
        .res_flag    (res_flag),
        .ovf_sticky  (ovf_sticky),
        .clr_sticky  (clr_sticky),
        .cnt_ops     (cnt_ops)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one command with res_ready=1, return the delivered result
    task automatic do_cmd(input logic [1:0] op, input logic carrega, input logic [7:0] dado,
                          input logic clr_mid, output logic [7:0] r_dado,
                          output logic r_flag, output logic r_ok);
        int n;
        r_ok = 1'b1;
        res_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) r_ok = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_carrega = carrega;
        cmd_dado    = dado;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        clr_sticky = clr_mid;
        n = 0;
        while (!res_valid && n < 10) begin
            @(posedge clk); #1;
            clr_sticky = 1'b0;
            n++;
        end
        clr_sticky = 1'b0;
        if (!res_valid) r_ok = 1'b0;
        r_dado = res_dado;
        r_flag = res_flag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
        tests_run++; if (res_dado !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_res_dado: got %h expected 00", res_dado); end
        tests_run++; if (res_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_res_flag: got %b expected 0", res_flag); end
        tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sticky: got %b expected 0", ovf_sticky); end
        tests_run++; if (cnt_ops !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt_ops); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_add();
        do_cmd(OP_ADD, 1'b1, 8'd100, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h64 || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_100: got %h/%b ok=%b expected 64/0", got, got_f, ok); end
        do_cmd(OP_ADD, 1'b0, 8'd27, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h7F || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_27: got %h/%b ok=%b expected 7f/0", got, got_f, ok); end
        tests_run++; if (cnt_ops !== 8'd2) begin tests_failed++; $display("[TB] FAIL cnt_after_two: got %0d expected 2", cnt_ops); end
    endtask

    task automatic test_overflow_add();
        do_cmd(OP_ADD, 1'b0, 8'd1, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h80 || got_f !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_ovf: got %h/%b ok=%b expected 80/1", got, got_f, ok); end
        tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("[TB] FAIL sticky_set: got %b expected 1", ovf_sticky); end
        do_cmd(OP_AND, 1'b0, 8'h0F, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h00 || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_0f: got %h/%b ok=%b expected 00/0", got, got_f, ok); end
        tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("[TB] FAIL sticky_hold: got %b expected 1", ovf_sticky); end
    endtask

    task automatic test_or_sub();
        do_cmd(OP_ADD, 1'b1, 8'h7F, 1'b0, got, got_f, ok);
        do_cmd(OP_OR, 1'b0, 8'h80, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'hFF || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL or_80: got %h/%b ok=%b expected ff/0", got, got_f, ok); end
        do_cmd(OP_SUB, 1'b0, 8'd5, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'hFA || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL sub_5: got %h/%b ok=%b expected fa/0", got, got_f, ok); end
        do_cmd(OP_ADD, 1'b1, 8'd100, 1'b0, got, got_f, ok);
        do_cmd(OP_SUB, 1'b0, 8'h9C, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'hC8 || got_f !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_neg100_ovf: got %h/%b ok=%b expected c8/1", got, got_f, ok); end
    endtask

    task automatic test_sub_sticky();
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("[TB] FAIL sticky_clear_first: got %b expected 0", ovf_sticky); end
        do_cmd(OP_ADD, 1'b1, 8'h80, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h80 || got_f !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_neg128: got %h/%b ok=%b expected 80/0", got, got_f, ok); end
        do_cmd(OP_SUB, 1'b0, 8'd1, 1'b1, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'h7F || got_f !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_ovf: got %h/%b ok=%b expected 7f/1", got, got_f, ok); end
        tests_run++; if (ovf_sticky !== 1'b1) begin tests_failed++; $display("[TB] FAIL sticky_set_wins: got %b expected 1", ovf_sticky); end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        tests_run++; if (ovf_sticky !== 1'b0) begin tests_failed++; $display("[TB] FAIL sticky_clear: got %b expected 0", ovf_sticky); end
    endtask

    task automatic test_stall();
        int n;
        res_ready   = 1'b0;
        cmd_valid   = 1'b1;
        cmd_carrega = 1'b1;
        cmd_op      = OP_AND;
        cmd_dado    = 8'd42;
        @(posedge clk); #1;
        cmd_carrega = 1'b0;
        cmd_op      = OP_ADD;
        cmd_dado    = 8'd1;
        n = 0;
        while (!res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, res_valid); end
            tests_run++; if (res_dado !== 8'd42) begin tests_failed++; $display("[TB] FAIL stall_dado[%0d]: got %h expected 2a", i, res_dado); end
            tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_cmd_ready[%0d]: got %b expected 0", i, cmd_ready); end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_release: valid=%b ready=%b expected 0/1", res_valid, cmd_ready); end
        do_cmd(OP_AND, 1'b0, 8'hFF, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'd42) begin tests_failed++; $display("[TB] FAIL stall_acc_kept: got %h ok=%b expected 2a", got, ok); end
    endtask

    task automatic test_back_to_back();
        res_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_carrega = 1'b1;
        cmd_op      = OP_AND;
        cmd_dado    = 8'd7;
        @(posedge clk); #1;
        cmd_carrega = 1'b0;
        cmd_op      = OP_ADD;
        cmd_dado    = 8'd1;
        tests_run++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_exec: valid=%b ready=%b expected 0/0", res_valid, cmd_ready); end
        @(posedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_dado !== 8'd7) begin tests_failed++; $display("[TB] FAIL b2b_first: valid=%b dado=%h expected 1/07", res_valid, res_dado); end
        @(posedge clk); #1;
        tests_run++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: ready=%b valid=%b expected 1/0", cmd_ready, res_valid); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (res_valid !== 1'b1 || res_dado !== 8'd8) begin tests_failed++; $display("[TB] FAIL b2b_second: valid=%b dado=%h expected 1/08", res_valid, res_dado); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_cmd(OP_ADD, 1'b1, 8'd10, 1'b0, got, got_f, ok);
        cmd_valid   = 1'b1;
        cmd_carrega = 1'b0;
        cmd_op      = OP_ADD;
        cmd_dado    = 8'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_hs: ready=%b valid=%b expected 1/0", cmd_ready, res_valid); end
        tests_run++; if (res_dado !== 8'h00 || res_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_res: dado=%h flag=%b expected 00/0", res_dado, res_flag); end
        tests_run++; if (cnt_ops !== 8'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_cnt: got %0d expected 0", cnt_ops); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (res_dado !== 8'h00 || cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_after: dado=%h ready=%b expected 00/1", res_dado, cmd_ready); end
        do_cmd(OP_ADD, 1'b0, 8'd3, 1'b0, got, got_f, ok);
        tests_run++; if (!ok || got !== 8'd3) begin tests_failed++; $display("[TB] FAIL rst_mid_acc_zero: got %h ok=%b expected 03", got, ok); end
    endtask

    task automatic test_cnt_wrap();
        int bad;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            do_cmd(OP_ADD, 1'b1, 8'(i), 1'b0, got, got_f, ok);
            if (!ok || got !== 8'(i)) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL wrap_loads: %0d bad results expected 0", bad); end
        tests_run++; if (cnt_ops !== 8'd255) begin tests_failed++; $display("[TB] FAIL cnt_255: got %0d expected 255", cnt_ops); end
        do_cmd(OP_ADD, 1'b1, 8'd1, 1'b0, got, got_f, ok);
        tests_run++; if (cnt_ops !== 8'd0) begin tests_failed++; $display("[TB] FAIL cnt_wrap: got %0d expected 0", cnt_ops); end
    endtask

    // Scenario sequence and summary
    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_carrega = 1'b0;
        cmd_dado    = 8'd0;
        res_ready   = 1'b1;
        clr_sticky  = 1'b0;
        test_reset();
        test_load_add();
        test_overflow_add();
        test_or_sub();
        test_sub_sticky();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
